// File: rtl/operand_demux_if.sv
// ---------------------------------------------------------------------------
// operand_demux_if
//   Bundles the operand input handshake and the per-lane output handshake of
//   operand_demux.
//
//   master : the environment around the demux (the operand source plus the
//            MAC lane consumers). It drives in_* and out_ready.
//   slave  : the demux itself. It drives in_ready, out_*, lane_ptr and
//            frame_done.
//
//   Signals
//     in_data    [WIDTH]        operand word
//     in_valid                  in_data valid
//     in_ready                  demux can take in_data this cycle
//     in_mode                   0 = round-robin, 1 = addressed
//     in_sel     [SEL_W]        target lane in addressed mode
//     out_data   [LANES*WIDTH]  lane k on bits [k*WIDTH +: WIDTH]
//     out_valid  [LANES]        lane k holds a word
//     out_ready  [LANES]        lane k consumer takes its word
//     lane_ptr   [SEL_W]        round-robin pointer
//     frame_done                one-cycle pulse at the end of a round-robin frame
// ---------------------------------------------------------------------------
interface operand_demux_if #(
  parameter int WIDTH = 8,
  parameter int LANES = 4
);
  localparam int SEL_W = $clog2(LANES);

  logic [WIDTH-1:0]       in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_mode;
  logic [SEL_W-1:0]       in_sel;
  logic [LANES*WIDTH-1:0] out_data;
  logic [LANES-1:0]       out_valid;
  logic [LANES-1:0]       out_ready;
  logic [SEL_W-1:0]       lane_ptr;
  logic                   frame_done;

  modport master (
    output in_data, in_valid, in_mode, in_sel, out_ready,
    input  in_ready, out_data, out_valid, lane_ptr, frame_done
  );

  modport slave (
    input  in_data, in_valid, in_mode, in_sel, out_ready,
    output in_ready, out_data, out_valid, lane_ptr, frame_done
  );
endinterface

// File: rtl/operand_demux.sv
// ---------------------------------------------------------------------------
// operand_demux
//   Sequential 1-to-LANES demultiplexer at the distribution end of the operand
//   path. One WIDTH-bit word per cycle is accepted on a valid/ready input and
//   steered into one of LANES single-entry output registers feeding the MAC
//   lanes. The target lane is either the round-robin pointer (frame fill,
//   in_mode=0) or in_sel (addressed, in_mode=1).
//
//   Ports
//     clk   rising-edge clock
//     rst   asynchronous, active-high reset (clears data, valids, pointer,
//           frame_done)
//     bus   operand_demux_if.slave, carrying in_* handshake, per-lane out_*
//           handshake, lane_ptr and frame_done
// ---------------------------------------------------------------------------
module operand_demux #(
  parameter int WIDTH = 8,
  parameter int LANES = 4
) (
  input  logic            clk,
  input  logic            rst,
  operand_demux_if.slave  bus
);
  localparam int SEL_W = $clog2(LANES);
  localparam logic [SEL_W-1:0] LAST_LANE = SEL_W'(LANES - 1);

  logic [LANES*WIDTH-1:0] out_data_q,   out_data_d;
  logic [LANES-1:0]       out_valid_q,  out_valid_d;
  logic [SEL_W-1:0]       lane_ptr_q,   lane_ptr_d;
  logic                   frame_done_q, frame_done_d;

  logic [SEL_W-1:0]       tgt;
  logic                   in_ready;
  logic                   acc;

  // Ready looks only at the selected lane, never at in_valid, so the source
  // can see whether a word would be taken before committing to it. A lane
  // being drained this cycle counts as free, which gives one word per cycle
  // per lane with no bubble.
  always_comb begin
    tgt      = bus.in_mode ? bus.in_sel : lane_ptr_q;
    in_ready = ~out_valid_q[tgt] | bus.out_ready[tgt];
    acc      = bus.in_valid & in_ready;
  end

  always_comb begin
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    lane_ptr_d   = lane_ptr_q;
    frame_done_d = 1'b0;

    // A load wins over a drain on the same lane: the old word leaves and the
    // new one takes its place in the same edge. A drained lane keeps its
    // last data; only the valid bit drops.
    for (int k = 0; k < LANES; k++) begin
      if (acc && (tgt == SEL_W'(k))) begin
        out_data_d[k*WIDTH +: WIDTH] = bus.in_data;
        out_valid_d[k]               = 1'b1;
      end else if (out_valid_q[k] && bus.out_ready[k]) begin
        out_valid_d[k] = 1'b0;
      end
    end

    // Addressed writes leave the pointer alone so a partially filled
    // round-robin frame can resume where it stopped.
    if (acc && !bus.in_mode) begin
      frame_done_d = (lane_ptr_q == LAST_LANE);
      lane_ptr_d   = (lane_ptr_q == LAST_LANE) ? '0 : lane_ptr_q + SEL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q   <= '0;
      out_valid_q  <= '0;
      lane_ptr_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      lane_ptr_q   <= lane_ptr_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_data   = out_data_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.lane_ptr   = lane_ptr_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_operand_demux.sv
module tb_operand_demux;
  localparam int WIDTH = 8;
  localparam int LANES = 4;
  localparam int SEL_W = $clog2(LANES);
  localparam int SB_D  = 256;

  logic clk = 1'b0;
  logic rst;

  operand_demux_if #(.WIDTH(WIDTH), .LANES(LANES)) bus ();
  operand_demux #(.WIDTH(WIDTH), .LANES(LANES)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural view of the lanes: what each lane holds, where the next
  // round-robin word goes, and whether a frame just closed.
  logic [WIDTH-1:0] m_data [LANES];
  bit               m_valid[LANES];
  int               m_ptr;
  bit               m_fd;

  // Per-lane FIFO of words accepted but not yet consumed.
  logic [WIDTH-1:0] sb_mem[LANES][SB_D];
  int               sb_wr[LANES];
  int               sb_rd[LANES];

  function automatic logic [WIDTH-1:0] lane_out(int k);
    return bus.out_data[k*WIDTH +: WIDTH];
  endfunction

  function automatic logic [LANES-1:0] model_vvec();
    logic [LANES-1:0] v;
    for (int k = 0; k < LANES; k++) v[k] = m_valid[k];
    return v;
  endfunction

  function automatic int model_tgt();
    return bus.in_mode ? int'(bus.in_sel) : m_ptr;
  endfunction

  function automatic bit model_rdy();
    int t;
    t = model_tgt();
    return !m_valid[t] || bus.out_ready[t];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < LANES; k++) begin
      m_data[k]  = '0;
      m_valid[k] = 1'b0;
      sb_wr[k]   = 0;
      sb_rd[k]   = 0;
    end
    m_ptr = 0;
    m_fd  = 1'b0;
  endtask

  // Advance one clock; the model consumes the inputs presented before the
  // edge and is updated just after it.
  task automatic tick();
    int               t;
    bit               acc;
    logic [WIDTH-1:0] nd[LANES];
    bit               nv[LANES];
    int               np;
    bit               nf;
    t   = model_tgt();
    acc = bus.in_valid && model_rdy();
    for (int k = 0; k < LANES; k++) begin
      nd[k] = m_data[k];
      nv[k] = m_valid[k] && !bus.out_ready[k];
    end
    if (acc) begin
      nd[t] = bus.in_data;
      nv[t] = 1'b1;
    end
    np = m_ptr;
    nf = 1'b0;
    if (acc && !bus.in_mode) begin
      nf = (m_ptr == LANES - 1);
      np = (m_ptr + 1) % LANES;
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < LANES; k++) begin
      m_data[k]  = nd[k];
      m_valid[k] = nv[k];
    end
    m_ptr = np;
    m_fd  = nf;
  endtask

  task automatic idle_inputs();
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.in_mode   = 1'b0;
    bus.in_sel    = '0;
    bus.out_ready = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    model_reset();
    #12;
    total++; if (bus.out_valid !== '0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.out_data !== '0) begin bad++; $display("FAIL reset_out_data got=%h want=0", bus.out_data); end
    total++; if (bus.lane_ptr !== '0) begin bad++; $display("FAIL reset_lane_ptr got=%0d want=0", bus.lane_ptr); end
    total++; if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b want=0", bus.frame_done); end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_rr_fill();
    logic [WIDTH-1:0] w;
    bus.in_mode   = 1'b0;
    bus.out_ready = '0;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      w = WIDTH'(8'h11 * (i + 1));
      bus.in_data = w;
      #1;
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rr_in_ready[%0d] got=%b want=1", i, bus.in_ready); end
      tick();
      total++; if (bus.frame_done !== (i == LANES - 1)) begin bad++; $display("FAIL rr_frame_done[%0d] got=%b want=%b", i, bus.frame_done, i == LANES - 1); end
    end
    total++; if (bus.out_valid !== 4'b1111) begin bad++; $display("FAIL rr_out_valid got=%b want=1111", bus.out_valid); end
    total++; if (bus.out_data !== 32'h44332211) begin bad++; $display("FAIL rr_out_data got=%h want=44332211", bus.out_data); end
    total++; if (bus.lane_ptr !== '0) begin bad++; $display("FAIL rr_lane_ptr got=%0d want=0", bus.lane_ptr); end
    bus.in_data = 8'h55;
    #1;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rr_full_in_ready got=%b want=0", bus.in_ready); end
    bus.in_valid = 1'b0;
    tick();
    total++; if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL rr_frame_done_pulse got=%b want=0", bus.frame_done); end
  endtask

  task automatic test_backpressure();
    bus.in_mode   = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h55;
    bus.out_ready = '0;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d] got=%b want=0", c, bus.in_ready); end
      tick();
      total++; if (bus.out_data !== 32'h44332211) begin bad++; $display("FAIL bp_hold_data[%0d] got=%h want=44332211", c, bus.out_data); end
      total++; if (bus.lane_ptr !== '0 || bus.out_valid !== 4'b1111) begin bad++; $display("FAIL bp_hold_ctl[%0d] got ptr=%0d valid=%b want ptr=0 valid=1111", c, bus.lane_ptr, bus.out_valid); end
    end
    bus.out_ready = 4'b0001;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_in_ready got=%b want=1", bus.in_ready); end
    tick();
    total++; if (lane_out(0) !== 8'h55) begin bad++; $display("FAIL bp_lane0 got=%h want=55", lane_out(0)); end
    total++; if (bus.out_valid !== 4'b1111) begin bad++; $display("FAIL bp_valid got=%b want=1111", bus.out_valid); end
    total++; if (bus.lane_ptr !== SEL_W'(1)) begin bad++; $display("FAIL bp_lane_ptr got=%0d want=1", bus.lane_ptr); end
    bus.in_valid  = 1'b0;
    bus.out_ready = '0;
  endtask

  task automatic test_addressed();
    bus.in_mode   = 1'b1;
    bus.in_sel    = SEL_W'(3);
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hA5;
    bus.out_ready = 4'b0100;
    #1;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL addr_stall_in_ready got=%b want=0", bus.in_ready); end
    bus.in_sel = SEL_W'(2);
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL addr_in_ready got=%b want=1", bus.in_ready); end
    tick();
    total++; if (lane_out(2) !== 8'hA5) begin bad++; $display("FAIL addr_lane2 got=%h want=a5", lane_out(2)); end
    total++; if (bus.lane_ptr !== SEL_W'(1)) begin bad++; $display("FAIL addr_lane_ptr got=%0d want=1", bus.lane_ptr); end
    total++; if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL addr_frame_done got=%b want=0", bus.frame_done); end
    total++; if (bus.out_data !== 32'h44A52255) begin bad++; $display("FAIL addr_out_data got=%h want=44a52255", bus.out_data); end
    bus.in_valid  = 1'b0;
    bus.in_mode   = 1'b0;
    bus.out_ready = '0;
  endtask

  task automatic test_async_reset();
    #2;
    rst = 1'b1;
    #1;
    total++; if (bus.out_valid !== '0) begin bad++; $display("FAIL areset_out_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.lane_ptr !== '0) begin bad++; $display("FAIL areset_lane_ptr got=%0d want=0", bus.lane_ptr); end
    total++; if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL areset_frame_done got=%b want=0", bus.frame_done); end
    total++; if (bus.out_data !== '0) begin bad++; $display("FAIL areset_out_data got=%h want=0", bus.out_data); end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_streaming();
    logic [WIDTH-1:0] w;
    bus.in_mode   = 1'b0;
    bus.out_ready = '1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      w = WIDTH'($urandom);
      bus.in_data = w;
      #1;
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready[%0d] got=%b want=1", i, bus.in_ready); end
      tick();
      total++; if (lane_out(i % LANES) !== w || bus.out_valid[i % LANES] !== 1'b1) begin bad++; $display("FAIL stream_lane[%0d] got=%h/%b want=%h/1", i, lane_out(i % LANES), bus.out_valid[i % LANES], w); end
      total++; if (bus.frame_done !== (i % LANES == LANES - 1)) begin bad++; $display("FAIL stream_frame_done[%0d] got=%b want=%b", i, bus.frame_done, i % LANES == LANES - 1); end
      total++; if (int'(bus.lane_ptr) !== (i + 1) % LANES) begin bad++; $display("FAIL stream_lane_ptr[%0d] got=%0d want=%0d", i, bus.lane_ptr, (i + 1) % LANES); end
    end
    bus.in_valid = 1'b0;
    tick();
    total++; if (bus.out_valid !== '0) begin bad++; $display("FAIL stream_drained got=%b want=0", bus.out_valid); end
  endtask

  task automatic test_random();
    int t;
    for (int c = 0; c < 10000; c++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_mode   = ($urandom_range(0, 2) == 0);
      bus.in_sel    = SEL_W'($urandom);
      bus.in_data   = WIDTH'($urandom);
      bus.out_ready = LANES'($urandom);
      #1;
      total++; if (bus.in_ready !== model_rdy()) begin bad++; $display("FAIL rand_in_ready[%0d] got=%b want=%b", c, bus.in_ready, model_rdy()); end
      for (int k = 0; k < LANES; k++) begin
        if (bus.out_valid[k] === 1'b1 && bus.out_ready[k]) begin
          total++;
          if (sb_rd[k] == sb_wr[k]) begin
            bad++; $display("FAIL rand_dup lane%0d cycle%0d got=%h want=no word", k, c, lane_out(k));
          end else begin
            if (lane_out(k) !== sb_mem[k][sb_rd[k] % SB_D]) begin bad++; $display("FAIL rand_order lane%0d cycle%0d got=%h want=%h", k, c, lane_out(k), sb_mem[k][sb_rd[k] % SB_D]); end
            sb_rd[k]++;
          end
        end
      end
      if (bus.in_valid && model_rdy()) begin
        t = model_tgt();
        sb_mem[t][sb_wr[t] % SB_D] = bus.in_data;
        sb_wr[t]++;
      end
      tick();
      total++; if (bus.out_valid !== model_vvec() || int'(bus.lane_ptr) !== m_ptr || bus.frame_done !== m_fd) begin
        bad++; $display("FAIL rand_state[%0d] got valid=%b ptr=%0d fd=%b want valid=%b ptr=%0d fd=%b", c, bus.out_valid, bus.lane_ptr, bus.frame_done, model_vvec(), m_ptr, m_fd);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = '1;
    #1;
    for (int k = 0; k < LANES; k++) begin
      if (bus.out_valid[k] === 1'b1) begin
        total++;
        if (sb_rd[k] == sb_wr[k] || lane_out(k) !== sb_mem[k][sb_rd[k] % SB_D]) begin bad++; $display("FAIL rand_final lane%0d got=%h", k, lane_out(k)); end
        else sb_rd[k]++;
      end
    end
    tick();
    for (int k = 0; k < LANES; k++) begin
      total++; if (sb_rd[k] != sb_wr[k]) begin bad++; $display("FAIL rand_loss lane%0d got=%0d delivered want=%0d", k, sb_rd[k], sb_wr[k]); end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_rr_fill();
    test_backpressure();
    test_addressed();
    test_async_reset();
    test_streaming();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
